// File: rtl/tick2trade_pkg.sv
// Shared constants for the tick2trade ingress path: write-FSM encodings and counter width.
package tick2trade_pkg;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_RECV = 2'd1;
  localparam logic [1:0] WR_DROP = 2'd2;

  localparam int unsigned CNT_WIDTH = 32;

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port (block-RAM style).
module pkt_fifo_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pkt_ingress_fifo.sv
// Store-and-forward Avalon-ST packet FIFO: packets become visible on egress only once
// committed by a clean EOP; errored, truncated or oversize packets are rewound and counted.
module pkt_ingress_fifo
  import tick2trade_pkg::*;
#(
  parameter int unsigned C_PKT_BEAT_BYTES   = 8,
  parameter int unsigned C_FIFO_DEPTH_BEATS = 256,
  parameter int unsigned C_CNT_WIDTH        = CNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  input  logic                                in_startofpacket,
  input  logic                                in_endofpacket,
  input  logic [8*C_PKT_BEAT_BYTES-1:0]       in_data,
  input  logic [$clog2(C_PKT_BEAT_BYTES)-1:0] in_empty,
  input  logic                                in_error,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic                                out_startofpacket,
  output logic                                out_endofpacket,
  output logic [8*C_PKT_BEAT_BYTES-1:0]       out_data,
  output logic [$clog2(C_PKT_BEAT_BYTES)-1:0] out_empty,
  output logic                                out_error,
  input  logic                                out_ready,
  output logic [C_CNT_WIDTH-1:0]              pkt_pass_cnt,
  output logic [C_CNT_WIDTH-1:0]              pkt_drop_cnt
);

  localparam int unsigned DW  = 8 * C_PKT_BEAT_BYTES;
  localparam int unsigned EW  = $clog2(C_PKT_BEAT_BYTES);
  localparam int unsigned AW  = $clog2(C_FIFO_DEPTH_BEATS);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned RW  = DW + EW + 2;
  localparam int unsigned CW  = C_CNT_WIDTH;
  localparam int unsigned CW1 = CW + 1;

  logic [1:0]    state, state_nx;
  logic [PW-1:0] wr_ptr, wr_nx, cm_ptr, cm_nx, rd_ptr;
  logic          we, re, full, cm_full;
  logic [AW-1:0] waddr;
  logic [RW-1:0] wdata, ram_rdata, skid_word, out_word;
  logic          pass_inc;
  logic [1:0]    drop_inc;
  logic [CW:0]   pass_sum, drop_sum;
  logic          ram_vld, skid_vld, pop, keep;
  logic [1:0]    occ;

  // Ingress is never back-pressured; only held off while in reset.
  assign in_ready  = reset_n;
  assign out_error = 1'b0;

  assign full    = (wr_ptr - rd_ptr) == PW'(C_FIFO_DEPTH_BEATS);
  assign cm_full = (cm_ptr - rd_ptr) == PW'(C_FIFO_DEPTH_BEATS);
  assign wdata   = {in_startofpacket, in_endofpacket, in_empty, in_data};

  // Write FSM: any SOP restarts at cm_ptr, discarding an open packet if one exists.
  always_comb begin
    state_nx = state;
    wr_nx    = wr_ptr;
    cm_nx    = cm_ptr;
    we       = 1'b0;
    waddr    = wr_ptr[AW-1:0];
    pass_inc = 1'b0;
    drop_inc = 2'd0;
    if (in_valid) begin
      if (in_startofpacket) begin
        if (state == WR_RECV) drop_inc = 2'd1;
        wr_nx = cm_ptr;
        if (cm_full) begin
          drop_inc = drop_inc + 2'd1;
          state_nx = in_endofpacket ? WR_IDLE : WR_DROP;
        end else begin
          we    = 1'b1;
          waddr = cm_ptr[AW-1:0];
          if (!in_endofpacket) begin
            wr_nx    = cm_ptr + PW'(1);
            state_nx = WR_RECV;
          end else if (in_error) begin
            drop_inc = drop_inc + 2'd1;
            state_nx = WR_IDLE;
          end else begin
            wr_nx    = cm_ptr + PW'(1);
            cm_nx    = cm_ptr + PW'(1);
            pass_inc = 1'b1;
            state_nx = WR_IDLE;
          end
        end
      end else if (state == WR_RECV) begin
        if (full) begin
          wr_nx    = cm_ptr;
          drop_inc = 2'd1;
          state_nx = in_endofpacket ? WR_IDLE : WR_DROP;
        end else begin
          we    = 1'b1;
          wr_nx = wr_ptr + PW'(1);
          if (in_endofpacket) begin
            state_nx = WR_IDLE;
            if (in_error) begin
              wr_nx    = cm_ptr;
              drop_inc = 2'd1;
            end else begin
              cm_nx    = wr_ptr + PW'(1);
              pass_inc = 1'b1;
            end
          end
        end
      end else if (state == WR_DROP && in_endofpacket) begin
        state_nx = WR_IDLE;
      end
    end
  end

  assign pass_sum = {1'b0, pkt_pass_cnt} + CW1'(pass_inc);
  assign drop_sum = {1'b0, pkt_drop_cnt} + CW1'(drop_inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WR_IDLE;
      wr_ptr       <= '0;
      cm_ptr       <= '0;
      pkt_pass_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      state        <= state_nx;
      wr_ptr       <= wr_nx;
      cm_ptr       <= cm_nx;
      pkt_pass_cnt <= pass_sum[CW] ? '1 : pass_sum[CW-1:0];
      pkt_drop_cnt <= drop_sum[CW] ? '1 : drop_sum[CW-1:0];
    end
  end

  pkt_fifo_ram #(.AW(AW), .DW(RW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Egress: read in flight + skid + output register; reads issue only while a slot is guaranteed.
  assign pop  = out_valid & out_ready;
  assign keep = out_valid & ~out_ready;
  assign occ  = 2'(keep) + 2'(skid_vld) + 2'(ram_vld);
  assign re   = (rd_ptr != cm_ptr) && (occ < 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      ram_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_word <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      ram_vld <= re;
      if (re) rd_ptr <= rd_ptr + PW'(1);
      if (!keep) begin
        if (skid_vld) begin
          out_valid <= 1'b1;
          out_word  <= skid_word;
          skid_vld  <= ram_vld;
          if (ram_vld) skid_word <= ram_rdata;
        end else begin
          out_valid <= ram_vld;
          if (ram_vld) out_word <= ram_rdata;
        end
      end else if (ram_vld) begin
        skid_vld  <= 1'b1;
        skid_word <= ram_rdata;
      end
    end
  end

  assign out_startofpacket = out_word[RW-1];
  assign out_endofpacket   = out_word[RW-2];
  assign out_empty         = out_word[DW+EW-1:DW];
  assign out_data          = out_word[DW-1:0];

endmodule

// File: tb/tb_pkt_ingress_fifo.sv
// Scoreboard bench for pkt_ingress_fifo (depth 8): stimulus pushes expected beats, a monitor pops them.
module tb_pkt_ingress_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_startofpacket, in_endofpacket, in_error;
  logic [63:0] in_data;
  logic [2:0]  in_empty;
  logic        in_ready;
  logic        out_valid, out_startofpacket, out_endofpacket, out_error;
  logic [63:0] out_data;
  logic [2:0]  out_empty;
  logic        out_ready;
  logic [31:0] pkt_pass_cnt, pkt_drop_cnt;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  e;
    logic [63:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  pkt_ingress_fifo #(
    .C_PKT_BEAT_BYTES   (8),
    .C_FIFO_DEPTH_BEATS (8),
    .C_CNT_WIDTH        (32)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_data           (in_data),
    .in_empty          (in_empty),
    .in_error          (in_error),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_data          (out_data),
    .out_empty         (out_empty),
    .out_error         (out_error),
    .out_ready         (out_ready),
    .pkt_pass_cnt      (pkt_pass_cnt),
    .pkt_drop_cnt      (pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic ok, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    check(name, got == exp, got, exp);
  endtask

  function automatic logic [63:0] mk(input int id, input int b);
    return {16'hBEEF, 16'(id), 16'h0000, 16'(b)};
  endfunction

  // Called at posedge+1; the beat is accepted on the following edge.
  task automatic drive_beat(input logic sop, input logic eop, input logic err,
                            input logic [63:0] d, input logic [2:0] e);
    in_valid = 1'b1; in_startofpacket = sop; in_endofpacket = eop;
    in_error = err; in_data = d; in_empty = e;
    @(posedge clk); #1;
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    in_error = 1'b0; in_data = '0; in_empty = '0;
  endtask

  task automatic send_pkt(input int id, input int len, input bit err, input bit exp_pass);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.sop = (b == 0);
      bt.eop = (b == len - 1);
      bt.e   = bt.eop ? 3'(id + b) : 3'd0;
      bt.d   = mk(id, b);
      if (exp_pass) exp_q.push_back(bt);
      drive_beat(bt.sop, bt.eop, err && bt.eop, bt.d, bt.e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: compares every transferred beat and checks hold-stability during stalls.
  initial begin
    beat_t got, exp, prev;
    logic  stalled;
    stalled = 1'b0;
    prev    = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
        continue;
      end
      got = {out_startofpacket, out_endofpacket, out_empty, out_data};
      if (stalled) check("hold_stable", out_valid && (got == prev), got.d, prev.d);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b0, got.d, 64'd0);
        end else begin
          exp = exp_q.pop_front();
          check("beat", got == exp, {got.sop, got.eop, got.e, got.d[58:0]},
                {exp.sop, exp.eop, exp.e, exp.d[58:0]});
          check_eq("out_error", 64'(out_error), 64'd0);
        end
      end
      stalled = out_valid && !out_ready;
      prev    = got;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lens[5] = '{1, 2, 3, 2, 1};
    reset_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    in_error = 1'b0; in_data = '0; in_empty = '0;

    // Reset state
    @(posedge clk); #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_sop", 64'(out_startofpacket), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_pass", 64'(pkt_pass_cnt), 64'd0);
    check_eq("rst_drop", 64'(pkt_drop_cnt), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("in_ready_after_rst", 64'(in_ready), 64'd1);

    // 3-beat good packet with latency bound
    send_pkt(1, 3, 1'b0, 1'b1);
    lat = 0;
    while (!out_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t1_latency", out_valid && lat <= 2, 64'(lat), 64'd2);
    drain("t1_drain");
    check_eq("t1_pass", 64'(pkt_pass_cnt), 64'd1);
    check_eq("t1_drop", 64'(pkt_drop_cnt), 64'd0);

    // Errored 4-beat packet then a good single-beat packet
    do_reset();
    send_pkt(2, 4, 1'b1, 1'b0);
    send_pkt(3, 1, 1'b0, 1'b1);
    drain("t2_drain");
    check_eq("t2_pass", 64'(pkt_pass_cnt), 64'd1);
    check_eq("t2_drop", 64'(pkt_drop_cnt), 64'd1);

    // Oversize packet with egress stalled, then a 2-beat packet
    do_reset();
    out_ready = 1'b0;
    send_pkt(4, 10, 1'b0, 1'b0);
    send_pkt(5, 2, 1'b0, 1'b1);
    idle(4);
    check_eq("t3_drop", 64'(pkt_drop_cnt), 64'd1);
    check_eq("t3_pass", 64'(pkt_pass_cnt), 64'd1);
    out_ready = 1'b1;
    drain("t3_drain");

    // SOP arrives at beat 2 of an open packet
    do_reset();
    drive_beat(1'b1, 1'b0, 1'b0, mk(6, 0), 3'd0);
    drive_beat(1'b0, 1'b0, 1'b0, mk(6, 1), 3'd0);
    send_pkt(7, 3, 1'b0, 1'b1);
    drain("t4_drain");
    check_eq("t4_drop", 64'(pkt_drop_cnt), 64'd1);
    check_eq("t4_pass", 64'(pkt_pass_cnt), 64'd1);

    // Five packets with out_ready toggling every cycle
    do_reset();
    fork
      begin
        repeat (80) begin
          out_ready = ~out_ready;
          @(posedge clk); #1;
        end
      end
      begin
        for (int p = 0; p < 5; p++) begin
          send_pkt(10 + p, lens[p], 1'b0, 1'b1);
          idle(4);
        end
      end
    join
    out_ready = 1'b1;
    drain("t5_drain");
    check_eq("t5_pass", 64'(pkt_pass_cnt), 64'd5);
    check_eq("t5_drop", 64'(pkt_drop_cnt), 64'd0);

    // Reset mid-packet with two committed packets buffered
    do_reset();
    out_ready = 1'b0;
    send_pkt(20, 2, 1'b0, 1'b1);
    send_pkt(21, 3, 1'b0, 1'b1);
    drive_beat(1'b1, 1'b0, 1'b0, mk(22, 0), 3'd0);
    drive_beat(1'b0, 1'b0, 1'b0, mk(22, 1), 3'd0);
    check_eq("t6_pass_pre", 64'(pkt_pass_cnt), 64'd2);
    check_eq("t6_valid_pre", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t6_rst_pass", 64'(pkt_pass_cnt), 64'd0);
    check_eq("t6_rst_drop", 64'(pkt_drop_cnt), 64'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    idle(10);
    check_eq("t6_no_stale", 64'(out_valid), 64'd0);
    send_pkt(23, 2, 1'b0, 1'b1);
    drain("t6_drain");
    check_eq("t6_pass_post", 64'(pkt_pass_cnt), 64'd1);
    check_eq("t6_drop_post", 64'(pkt_drop_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_ingress_fifo.md
PKT_INGRESS_FIFO -- requirements
Module: pkt_ingress_fifo

Interface
REQ-001 SHALL have parameter C_PKT_BEAT_BYTES, default 8, meaning bytes per Avalon-ST beat; data width = 8*C_PKT_BEAT_BYTES, empty width = clog2(C_PKT_BEAT_BYTES).
REQ-002 SHALL have parameter C_FIFO_DEPTH_BEATS, default 256, meaning buffer depth in beats; power of two, >= 4.
REQ-003 SHALL have parameter C_CNT_WIDTH, default 32, meaning width of statistics counters.
REQ-004 clk  input  1  core clock; all logic on rising edge.
REQ-005 reset_n  input  1  core reset, asynchronous assert, active-low.
REQ-006 in_valid, in_startofpacket, in_endofpacket  input  1 each  Avalon-ST ingress qualifiers.
REQ-007 in_data  input  8*C_PKT_BEAT_BYTES; in_empty  input  clog2(C_PKT_BEAT_BYTES); in_error  input  1  ingress payload, empty count, error flag.
REQ-008 in_ready  output  1  ingress ready.
REQ-009 out_valid, out_startofpacket, out_endofpacket  output  1 each; out_data, out_empty, out_error  output  same widths as ingress; out_ready  input  1  egress to feed_decoder.
REQ-010 pkt_pass_cnt, pkt_drop_cnt  output  C_CNT_WIDTH  committed / discarded packet counts.

Function
REQ-011 Block SHALL be store-and-forward: no beat of a packet appears on egress before its EOP beat has been accepted and committed.
REQ-012 in_ready SHALL be 1 whenever reset_n is high; ingress is never back-pressured; non-fitting packets are dropped.
REQ-013 Write FSM SHALL have states IDLE, RECV, DROP; write pointer wr_ptr, committed pointer cm_ptr, read pointer rd_ptr, all clog2(depth)+1 bits.
REQ-014 IDLE: valid beat without SOP SHALL be ignored, no counter change; valid SOP beat SHALL be written and go to RECV, or committed directly if EOP also set.
REQ-015 RECV: valid beat SHALL be written at wr_ptr and wr_ptr incremented.
REQ-016 EOP with in_error=0 SHALL set cm_ptr to wr_ptr+1, increment pkt_pass_cnt, return to IDLE.
REQ-017 EOP with in_error=1 SHALL restore wr_ptr to cm_ptr, increment pkt_drop_cnt, return to IDLE.
REQ-018 Full (wr_ptr - rd_ptr == C_FIFO_DEPTH_BEATS) on an accepted beat in RECV or a SOP beat SHALL restore wr_ptr to cm_ptr, increment pkt_drop_cnt, go to DROP (IDLE if beat is EOP).
REQ-019 SOP in RECV (missing EOP) SHALL discard partial packet (rewind, pkt_drop_cnt+1) and start the new packet with that beat in the same cycle.
REQ-020 DROP: beats SHALL be discarded until EOP (-> IDLE); SOP in DROP starts a new packet as in IDLE.
REQ-021 Packets longer than C_FIFO_DEPTH_BEATS SHALL always be dropped, never deadlock.
REQ-022 RAM word SHALL hold data, empty, SOP, EOP; out_error SHALL always be 0.
REQ-023 Egress SHALL read while rd_ptr != cm_ptr through registered RAM read plus output/skid register; out_valid SHALL rise no later than 2 cycles after the committing cycle when the egress is idle.
REQ-024 Egress SHALL obey Avalon-ST ready-latency 0: beat transfers when out_valid & out_ready; out_* held stable while out_valid & !out_ready; no bubbles within a packet while out_ready stays high.
REQ-025 Simultaneous commit, rewind and read in one cycle SHALL be correct; full-flag uses rd_ptr of that cycle before increment.
REQ-026 Counters SHALL saturate at all-ones.

Reset
REQ-027 Reset SHALL force FSM IDLE, wr_ptr=cm_ptr=rd_ptr=0, out_valid=0, out_startofpacket=0, out_endofpacket=0, out_data=0, out_empty=0, out_error=0, both counters 0, in_ready=0 while reset_n low.
REQ-028 Reset mid-packet SHALL discard all buffered and partial packets without counting them; RAM contents need no reset.

Structure
REQ-029 FSM state enum and counter width constant SHALL live in shared package tick2trade_pkg.
REQ-030 Storage SHALL be sub-module pkt_fifo_ram: simple dual-port RAM, one write port, one registered read port, inferable to block RAM.

Verification
REQ-031 3-beat packet, no error, out_ready=1 -> 3 beats out in order, SOP on beat 0, EOP+empty on beat 2, first out_valid <= 2 cycles after EOP, pkt_pass_cnt=1.
REQ-032 4-beat packet with in_error=1 on EOP -> no egress beats, pkt_drop_cnt=1, next good 1-beat packet emerges intact.
REQ-033 Depth 8, out_ready=0, 10-beat packet -> dropped, pkt_drop_cnt=1; subsequent 2-beat packet passes, pkt_pass_cnt=1.
REQ-034 SOP at beat 2 of open packet -> partial dropped, new packet passes unchanged, drop=1, pass=1.
REQ-035 out_ready toggled 1010... over 5 back-to-back packets -> all beats delivered in order, out_* stable while stalled.
REQ-036 reset_n low for 1 cycle mid-packet with 2 committed packets buffered -> out_valid=0 next edge, counters 0, no stale beats after release.
